// File: rtl/exu_dp_pkg.sv
// Shared constants and ALU opcode encoding for the execute-unit datapath.
// Opcode values above ALU_OPCODE_AND are undefined and make the ALU return 0.
package exu_dp_pkg;
    localparam int RV_XLEN    = 32;
    localparam int RV_GPR_NUM = 32;
    localparam int RV_GPR_AW  = 5;
    localparam int ALU_OP_W   = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OPCODE_ADD  = 4'd0,
        ALU_OPCODE_SUB  = 4'd1,
        ALU_OPCODE_SLL  = 4'd2,
        ALU_OPCODE_SRL  = 4'd3,
        ALU_OPCODE_SRA  = 4'd4,
        ALU_OPCODE_SLT  = 4'd5,
        ALU_OPCODE_SLTU = 4'd6,
        ALU_OPCODE_XOR  = 4'd7,
        ALU_OPCODE_OR   = 4'd8,
        ALU_OPCODE_AND  = 4'd9
    } alu_op_t;
endpackage

// File: rtl/exu_dp_if.sv
// Handler-to-datapath bundle: ALU operands/result, two GPR read ports, one write port.
// No handshake; gpr_wen is a single-cycle qualifier driven by the handler.
interface exu_dp_if;
    import exu_dp_pkg::*;

    logic [ALU_OP_W-1:0]  alu_opcode;
    logic [RV_XLEN-1:0]   alu_src1;
    logic [RV_XLEN-1:0]   alu_src2;
    logic [RV_XLEN-1:0]   alu_dst;
    logic [RV_GPR_AW-1:0] gpr_raddr1;
    logic [RV_GPR_AW-1:0] gpr_raddr2;
    logic [RV_XLEN-1:0]   gpr_rdata1;
    logic [RV_XLEN-1:0]   gpr_rdata2;
    logic [RV_GPR_AW-1:0] gpr_waddr;
    logic [RV_XLEN-1:0]   gpr_wdata;
    logic                 gpr_wen;

    modport slave (
        input  alu_opcode, alu_src1, alu_src2, gpr_raddr1, gpr_raddr2,
               gpr_waddr, gpr_wdata, gpr_wen,
        output alu_dst, gpr_rdata1, gpr_rdata2
    );
    modport master (
        output alu_opcode, alu_src1, alu_src2, gpr_raddr1, gpr_raddr2,
               gpr_waddr, gpr_wdata, gpr_wen,
        input  alu_dst, gpr_rdata1, gpr_rdata2
    );
endinterface

// File: rtl/exu_gpr_file.sv
// GPR storage with two asynchronous read ports, hardwired-zero x0 and write-to-read forwarding.
// Writes land on the rising edge (visible from storage next cycle); never stalls.
module exu_gpr_file #(
    parameter int GPR_NUM = 32,
    parameter int XLEN    = 32,
    parameter int AW      = $clog2(GPR_NUM)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            wen
);
    logic [XLEN-1:0] regs [GPR_NUM];
    logic            wr_live;

    // A write held during reset is discarded, so it must not be forwarded either.
    assign wr_live = wen && rst_n && (waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GPR_NUM; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (wr_live && waddr == raddr1) rdata1 = wdata;
        if (wr_live && waddr == raddr2) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end
endmodule

// File: rtl/exu_dp.sv
// Execute datapath: combinational ALU (0 cycles), GPR file and 64-bit writeback counter (+1 cycle).
// Slave of exu_dp_if with no backpressure; the ALU never reads the GPR ports, so alu_dst may feed gpr_wdata.
module exu_dp
    import exu_dp_pkg::*;
#(
    parameter int GPR_NUM = RV_GPR_NUM,
    parameter int XLEN    = RV_XLEN
) (
    input  logic        clk,
    input  logic        rst_n,
    exu_dp_if.slave     dp_ctrl,
    output logic [63:0] wb_cnt,
    input  logic        wb_cnt_clr
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [SHW-1:0]  shamt;
    logic [63:0]     wb_cnt_q;

    assign src1  = dp_ctrl.alu_src1;
    assign src2  = dp_ctrl.alu_src2;
    assign shamt = src2[SHW-1:0];

    always_comb begin
        dp_ctrl.alu_dst = '0;
        case (dp_ctrl.alu_opcode)
            ALU_OPCODE_ADD:  dp_ctrl.alu_dst = src1 + src2;
            ALU_OPCODE_SUB:  dp_ctrl.alu_dst = src1 - src2;
            ALU_OPCODE_SLL:  dp_ctrl.alu_dst = src1 << shamt;
            ALU_OPCODE_SRL:  dp_ctrl.alu_dst = src1 >> shamt;
            ALU_OPCODE_SRA:  dp_ctrl.alu_dst = $signed(src1) >>> shamt;
            ALU_OPCODE_SLT:  dp_ctrl.alu_dst = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            ALU_OPCODE_SLTU: dp_ctrl.alu_dst = {{(XLEN-1){1'b0}}, src1 < src2};
            ALU_OPCODE_XOR:  dp_ctrl.alu_dst = src1 ^ src2;
            ALU_OPCODE_OR:   dp_ctrl.alu_dst = src1 | src2;
            ALU_OPCODE_AND:  dp_ctrl.alu_dst = src1 & src2;
            default:         dp_ctrl.alu_dst = '0;
        endcase
    end

    exu_gpr_file #(
        .GPR_NUM (GPR_NUM),
        .XLEN    (XLEN)
    ) u_gpr (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (dp_ctrl.gpr_raddr1),
        .raddr2 (dp_ctrl.gpr_raddr2),
        .rdata1 (dp_ctrl.gpr_rdata1),
        .rdata2 (dp_ctrl.gpr_rdata2),
        .waddr  (dp_ctrl.gpr_waddr),
        .wdata  (dp_ctrl.gpr_wdata),
        .wen    (dp_ctrl.gpr_wen)
    );

    // Writes to x0 still count; clear takes priority over a same-cycle writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cnt_q <= '0;
        end else if (wb_cnt_clr) begin
            wb_cnt_q <= '0;
        end else if (dp_ctrl.gpr_wen) begin
            wb_cnt_q <= wb_cnt_q + 64'd1;
        end
    end

    assign wb_cnt = wb_cnt_q;
endmodule
